// File: rtl/rx_fcs_checker_if.sv
// Receive-side beat bus and status/counter bundle for the RX FCS checker.
// The master drives frame beats and observes status; the slave is the checker.
interface rx_fcs_checker_if;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [2:0]  in_bytes;
  logic        in_err;

  logic        stat_valid;
  logic        stat_good;
  logic        stat_fcs_ok;
  logic        stat_runt;
  logic        stat_oversize;
  logic        stat_phy_err;
  logic        stat_abort;
  logic [15:0] stat_len;
  logic [31:0] cnt_good;
  logic [31:0] cnt_bad;

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_bytes, in_err,
    input  stat_valid, stat_good, stat_fcs_ok, stat_runt, stat_oversize,
           stat_phy_err, stat_abort, stat_len, cnt_good, cnt_bad
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_bytes, in_err,
    output stat_valid, stat_good, stat_fcs_ok, stat_runt, stat_oversize,
           stat_phy_err, stat_abort, stat_len, cnt_good, cnt_bad
  );
endinterface

// File: rtl/rx_fcs_checker.sv
// RX Frame Check Sequence checker: runs CRC-32 (0x04C11DB7, MSB-first lanes,
// first wire byte on [63:56]) over each frame including its FCS, compares the
// register against the residue, and emits one status word per frame two
// clocks after the terminating beat is sampled. Keeps good/bad frame counters.
module rx_fcs_checker #(
  parameter int          MIN_LEN = 64,
  parameter int          MAX_LEN = 1518,
  parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
  input logic             clk,
  input logic             rst,
  rx_fcs_checker_if.slave rx_if
);

  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  typedef enum logic [0:0] {IDLE = 1'b0, FRAME = 1'b1} state_t;

  // One byte through the CRC, most-significant bit first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ b[i]) c = {c[30:0], 1'b0} ^ POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Byte-step chain over the first nbytes lanes, lane 0 = [63:56].
  function automatic logic [31:0] crc_lanes(input logic [31:0] crc, input logic [63:0] data,
                                            input logic [3:0] nbytes);
    logic [31:0] c;
    c = crc;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nbytes) c = crc_byte(c, data[63-8*k -: 8]);
    end
    return c;
  endfunction

  // Length accumulation that sticks at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] len_add_sat(input logic [15:0] len, input logic [3:0] n);
    logic [16:0] s;
    s = {1'b0, len} + {13'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // ---- stage 0: input beat register ----
  logic        vld_p0;
  logic [63:0] data_p0;
  logic        sop_p0;
  logic        eop_p0;
  logic [2:0]  bytes_p0;
  logic        err_p0;

  // Beat qualifier is the only control bit here, so only it is reset.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rx_if.in_valid;
  end

  // Beat payload capture.
  always_ff @(posedge clk) begin
    data_p0  <= rx_if.in_data;
    sop_p0   <= rx_if.in_sop;
    eop_p0   <= rx_if.in_eop;
    bytes_p0 <= rx_if.in_bytes;
    err_p0   <= rx_if.in_err;
  end

  // ---- frame tracking FSM and accumulators ----
  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        err_q, err_d;

  logic [3:0]  nb_p0;
  logic [31:0] beat_crc;
  logic [15:0] beat_len;
  logic        beat_err;
  logic        term;
  logic        t_abort;
  logic        t_disc;
  logic [31:0] t_crc;
  logic [15:0] t_len;
  logic        t_err;

  // Next-state and terminating-frame selection; an sop beat always restarts
  // from all-ones, zero length and a clean error flag.
  always_comb begin
    nb_p0    = (eop_p0 && bytes_p0 != 3'd0) ? {1'b0, bytes_p0} : 4'd8;
    beat_crc = crc_lanes(sop_p0 ? 32'hFFFF_FFFF : crc_q, data_p0, nb_p0);
    beat_len = len_add_sat(sop_p0 ? 16'd0 : len_q, nb_p0);
    beat_err = (sop_p0 ? 1'b0 : err_q) | err_p0;

    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    err_d   = err_q;
    term    = 1'b0;
    t_abort = 1'b0;
    t_disc  = 1'b0;
    t_crc   = beat_crc;
    t_len   = beat_len;
    t_err   = beat_err;

    if (vld_p0) begin
      case (state_q)
        IDLE: begin
          if (sop_p0) begin
            if (eop_p0) begin
              term = 1'b1;
            end else begin
              state_d = FRAME;
              crc_d   = beat_crc;
              len_d   = beat_len;
              err_d   = beat_err;
            end
          end
        end
        FRAME: begin
          if (sop_p0) begin
            // Report the interrupted frame; the new sop beat opens the next.
            term    = 1'b1;
            t_abort = 1'b1;
            t_len   = len_q;
            t_err   = err_q;
            if (eop_p0) begin
              t_disc  = 1'b1;
              state_d = IDLE;
            end else begin
              crc_d = beat_crc;
              len_d = beat_len;
              err_d = beat_err;
            end
          end else if (eop_p0) begin
            term    = 1'b1;
            state_d = IDLE;
          end else begin
            crc_d = beat_crc;
            len_d = beat_len;
            err_d = beat_err;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame state and running CRC/length/error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= 32'hFFFF_FFFF;
      len_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // ---- stage 1: final CRC, length and flags of a terminated frame ----
  logic        vld_p1;
  logic        disc_p1;
  logic        abort_p1;
  logic        err_p1;
  logic [31:0] crc_p1;
  logic [15:0] len_p1;

  // Stage-1 strobe.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= term;
  end

  // Stage-1 frame results, qualified by vld_p1.
  always_ff @(posedge clk) begin
    crc_p1   <= t_crc;
    len_p1   <= t_len;
    err_p1   <= t_err;
    abort_p1 <= t_abort;
    disc_p1  <= t_disc;
  end

  logic fcs_ok_p1;
  logic runt_p1;
  logic over_p1;
  logic good_p1;

  assign fcs_ok_p1 = !abort_p1 && (crc_p1 == RESIDUE);
  assign runt_p1   = len_p1 < MIN_L;
  assign over_p1   = len_p1 > MAX_L;
  assign good_p1   = fcs_ok_p1 && !runt_p1 && !over_p1 && !err_p1 && !abort_p1;

  // ---- stage 2: status outputs and counters ----
  logic        vld_p2;
  logic        good_p2;
  logic        fcs_ok_p2;
  logic        runt_p2;
  logic        over_p2;
  logic        phy_p2;
  logic        abort_p2;
  logic [15:0] len_p2;
  logic [31:0] cnt_good_q;
  logic [31:0] cnt_bad_q;

  // Status fields hold between strobes; a discarded single-beat frame behind
  // an abort costs the bad counter one extra count.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      good_p2    <= 1'b0;
      fcs_ok_p2  <= 1'b0;
      runt_p2    <= 1'b0;
      over_p2    <= 1'b0;
      phy_p2     <= 1'b0;
      abort_p2   <= 1'b0;
      len_p2     <= 16'd0;
      cnt_good_q <= 32'd0;
      cnt_bad_q  <= 32'd0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        good_p2   <= good_p1;
        fcs_ok_p2 <= fcs_ok_p1;
        runt_p2   <= runt_p1;
        over_p2   <= over_p1;
        phy_p2    <= err_p1;
        abort_p2  <= abort_p1;
        len_p2    <= len_p1;
        if (good_p1) cnt_good_q <= cnt_good_q + 32'd1;
        else         cnt_bad_q  <= cnt_bad_q + {30'd0, disc_p1, !disc_p1};
      end
    end
  end

  assign rx_if.stat_valid    = vld_p2;
  assign rx_if.stat_good     = good_p2;
  assign rx_if.stat_fcs_ok   = fcs_ok_p2;
  assign rx_if.stat_runt     = runt_p2;
  assign rx_if.stat_oversize = over_p2;
  assign rx_if.stat_phy_err  = phy_p2;
  assign rx_if.stat_abort    = abort_p2;
  assign rx_if.stat_len      = len_p2;
  assign rx_if.cnt_good      = cnt_good_q;
  assign rx_if.cnt_bad       = cnt_bad_q;

endmodule

// File: tb/tb_rx_fcs_checker.sv
// Bench for rx_fcs_checker: frames are built as byte queues with a table-driven
// CRC-32 model, sliced into beats, and every expected status (with its due
// cycle and counter values) is queued and checked by a negedge monitor.
module tb_rx_fcs_checker;

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam int          MIN_LEN = 64;
  localparam int          MAX_LEN = 1518;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          due;
    logic [15:0] len;
    logic        good;
    logic        fcs_ok;
    logic        runt;
    logic        over;
    logic        phy;
    logic        abort;
    int          cg;
    int          cb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_fcs_checker_if bus();

  rx_fcs_checker dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] tbl[256];
  exp_t        expq[$];
  bq_t         fq;
  int          last_due = 0;
  int          mcg = 0;
  int          mcb = 0;
  bit          open = 1'b0;
  int          open_len = 0;
  bit          open_err = 1'b0;
  logic [15:0] last_len = 16'd0;
  logic        last_good = 1'b0;
  bit          hold_ok = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_tab(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) c = {c[23:0], 8'h00} ^ tbl[c[31:24] ^ q[i]];
    return c;
  endfunction

  // Random payload followed by the inverted CRC, most significant byte first.
  task automatic build(input int ndata, input bit corrupt);
    logic [31:0] fcs;
    fq.delete();
    repeat (ndata) fq.push_back(8'($urandom));
    fcs = ~crc_tab(fq);
    fq.push_back(fcs[31:24]);
    fq.push_back(fcs[23:16]);
    fq.push_back(fcs[15:8]);
    fq.push_back(fcs[7:0]);
    if (corrupt && fq.size() > 10) fq[10] = fq[10] ^ 8'h01;
  endtask

  task automatic push_status(input int len, input bit fcs_ok, input bit phy, input bit abort,
                             input bit disc);
    exp_t e;
    e.due    = last_due;
    e.len    = (len > 65535) ? 16'hFFFF : 16'(len);
    e.fcs_ok = fcs_ok && !abort;
    e.runt   = e.len < 16'(MIN_LEN);
    e.over   = e.len > 16'(MAX_LEN);
    e.phy    = phy;
    e.abort  = abort;
    e.good   = e.fcs_ok && !e.runt && !e.over && !phy && !abort;
    if (e.good) mcg++;
    else        mcb += disc ? 2 : 1;
    e.cg = mcg;
    e.cb = mcb;
    expq.push_back(e);
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] nb, input logic er);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_bytes = nb;
    bus.in_err   = er;
    last_due     = cyc + 3;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = {$urandom, $urandom};
      bus.in_sop   = 1'($urandom);
      bus.in_eop   = 1'($urandom);
      bus.in_bytes = 3'($urandom);
      bus.in_err   = 1'($urandom);
    end
  endtask

  // stop_beats < 0 sends the whole frame; otherwise only that many beats
  // with no eop, leaving the frame open for a later abort.
  task automatic send_frame(input int stop_beats, input int err_beat);
    int          n;
    int          nbeats;
    int          lim;
    logic [63:0] d;
    bit          last;
    bit          anyerr;
    n      = fq.size();
    nbeats = (n + 7) / 8;
    lim    = (stop_beats >= 0) ? stop_beats : nbeats;
    anyerr = 1'b0;
    for (int b = 0; b < lim; b++) begin
      d = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) if (8*b + k < n) d[63-8*k -: 8] = fq[8*b + k];
      last = (stop_beats < 0) && (b == nbeats - 1);
      drive_beat(d, b == 0, last, last ? 3'(n % 8) : 3'($urandom), b == err_beat);
      if (b == 0 && open) begin
        push_status(open_len, 1'b0, open_err, 1'b1, last);
        open = 1'b0;
        if (last) return;
      end
      if (b == err_beat) anyerr = 1'b1;
    end
    if (stop_beats < 0) begin
      push_status(n, crc_tab(fq) == RESIDUE, anyerr, 1'b0, 1'b0);
    end else begin
      open     = 1'b1;
      open_len = 8 * lim;
      open_err = anyerr;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    hold_ok      = 1'b0;
    while (expq.size() > 0 && expq[expq.size()-1].due > cyc) void'(expq.pop_back());
    mcg  = 0;
    mcb  = 0;
    open = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    last_len  = 16'd0;
    last_good = 1'b0;
    chk("rst_stat_valid", 32'(bus.stat_valid), 32'd0);
    chk("rst_stat_good",  32'(bus.stat_good), 32'd0);
    chk("rst_stat_fcs",   32'(bus.stat_fcs_ok), 32'd0);
    chk("rst_stat_flags", 32'({bus.stat_runt, bus.stat_oversize, bus.stat_phy_err, bus.stat_abort}), 32'd0);
    chk("rst_stat_len",   32'(bus.stat_len), 32'd0);
    chk("rst_cnt_good",   bus.cnt_good, 32'd0);
    chk("rst_cnt_bad",    bus.cnt_bad, 32'd0);
    rst     = 1'b0;
    hold_ok = 1'b1;
  endtask

  // Strobe monitor: each expected status must appear exactly on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0 && expq[0].due <= cyc) begin
      e = expq.pop_front();
      chk("stat_valid", 32'(bus.stat_valid), 32'd1);
      chk("stat_len",   32'(bus.stat_len), 32'(e.len));
      chk("stat_good",  32'(bus.stat_good), 32'(e.good));
      chk("stat_fcs_ok", 32'(bus.stat_fcs_ok), 32'(e.fcs_ok));
      chk("stat_runt",  32'(bus.stat_runt), 32'(e.runt));
      chk("stat_oversize", 32'(bus.stat_oversize), 32'(e.over));
      chk("stat_phy_err", 32'(bus.stat_phy_err), 32'(e.phy));
      chk("stat_abort", 32'(bus.stat_abort), 32'(e.abort));
      chk("cnt_good",   bus.cnt_good, 32'(e.cg));
      chk("cnt_bad",    bus.cnt_bad, 32'(e.cb));
      last_len  = e.len;
      last_good = e.good;
    end else begin
      chk("no_strobe", 32'(bus.stat_valid), 32'd0);
      if (hold_ok) begin
        chk("hold_len",  32'(bus.stat_len), 32'(last_len));
        chk("hold_good", 32'(bus.stat_good), 32'(last_good));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int          eb;
    for (int i = 0; i < 256; i++) begin
      r = 32'(i) << 24;
      repeat (8) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      tbl[i] = r;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 64'd0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_bytes = 3'd0;
    bus.in_err   = 1'b0;

    do_reset(2);

    // good 64-byte frame, then the same length with a flipped bit
    build(60, 1'b0); send_frame(-1, -1); idle(3);
    build(60, 1'b1); send_frame(-1, -1); idle(2);
    // partial tails: 65 and 68 bytes
    build(61, 1'b0); send_frame(-1, -1); idle(1);
    build(64, 1'b0); send_frame(-1, -1); idle(1);
    // limits: 60 (runt), 1519 (oversize), 1518 (good)
    build(56, 1'b0);   send_frame(-1, -1); idle(1);
    build(1515, 1'b0); send_frame(-1, -1); idle(1);
    build(1514, 1'b0); send_frame(-1, -1); idle(1);
    // PHY error on beat 3
    build(60, 1'b0); send_frame(-1, 3); idle(2);
    // abort after 3 beats, new frame reports normally
    build(60, 1'b0); send_frame(3, -1);
    build(60, 1'b0); send_frame(-1, -1); idle(2);
    // three consecutive single-beat frames, then back-to-back multi-beat
    build(4, 1'b0); send_frame(-1, -1);
    build(2, 1'b0); send_frame(-1, -1);
    build(0, 1'b0); send_frame(-1, -1);
    build(70, 1'b0); send_frame(-1, -1);
    build(66, 1'b0); send_frame(-1, -1); idle(2);
    // abort by a single-beat frame: discarded, counts two bad
    build(60, 1'b0); send_frame(2, -1);
    build(3, 1'b0);  send_frame(-1, -1); idle(2);
    // stray non-sop beat in idle is ignored
    drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'd0, 1'b1);
    build(64, 1'b0); send_frame(-1, -1); idle(2);
    // randomized frames
    for (int i = 0; i < 25; i++) begin
      eb = -1;
      if ($urandom_range(0, 4) == 0) eb = int'($urandom_range(0, 3));
      build(int'($urandom_range(0, 200)), $urandom_range(0, 3) == 0);
      send_frame(-1, eb);
      idle(int'($urandom_range(0, 2)));
    end
    // length saturation
    build(65600, 1'b0); send_frame(-1, -1); idle(4);
    // reset one cycle after a mid-frame beat
    build(200, 1'b0); send_frame(3, -1);
    do_reset(2);
    // reset while a single-beat status is in the pipeline
    build(4, 1'b0); send_frame(-1, -1);
    do_reset(1);
    // normal operation after reset
    build(100, 1'b0); send_frame(-1, -1);
    idle(10);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
